// File: rtl/pattern_seq_pkg.sv
// pattern_seq_pkg: shared state encoding, reset defaults and length clamp for the pattern sequencer
package pattern_seq_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;
  localparam int DEF_LEN = 4;
  localparam int DEF_TARGET = 1;
  localparam logic DEF_OVERLAP = 1'b1;
  function automatic int clamp_len(input int len, input int max_len);
    return (len < 1) ? 1 : (len > max_len) ? max_len : len;
  endfunction
endpackage

// File: rtl/pattern_matcher.sv
// pattern_matcher: shift register, fill counter and length-masked compare producing a combinational hit
module pattern_matcher #(
  parameter int PAT_W = 4,
  parameter int LEN_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             no_overlap,
  input  logic             din,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  output logic             hit
);
  localparam int FW = $clog2(PAT_W + 1);
  logic [PAT_W-1:0] sh_q, sh_d, sh_n, mask;
  logic [FW-1:0] fill_q, fill_d, fill_n;
  always_comb begin
    sh_n = {sh_q[PAT_W-2:0], din};
    fill_n = (int'(fill_q) >= PAT_W) ? FW'(PAT_W) : fill_q + FW'(1);
    for (int i = 0; i < PAT_W; i++) mask[i] = i < int'(len);
    hit = en && (int'(fill_n) >= int'(len)) && (((sh_n ^ pattern) & mask) == '0);
    sh_d = clr ? '0 : en ? sh_n : sh_q;
    // non-overlapping mode restarts the fill so the next match needs len fresh bits
    fill_d = clr ? '0 : !en ? fill_q : (hit && no_overlap) ? '0 : fill_n;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q <= '0;
      fill_q <= '0;
    end else begin
      sh_q <= sh_d;
      fill_q <= fill_d;
    end
  end
endmodule

// File: rtl/pattern_seq_ctrl.sv
// pattern_seq_ctrl: arms/disarms serial pattern detection, counts matches and raises a sticky target irq
module pattern_seq_ctrl
  import pattern_seq_pkg::*;
#(
  parameter int PAT_W = DEF_LEN,
  parameter int LEN_W = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [CNT_W-1:0] cfg_target,
  input  logic             cfg_overlap,
  input  logic             start,
  input  logic             abort,
  input  logic             din,
  input  logic             din_valid,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             irq,
  output logic             busy
);
  state_e state_q, state_d;
  logic match_q, match_d, irq_q, irq_d, busy_q, busy_d, ovl_q, ovl_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, tgt_q, tgt_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic clr, arm, hit;
  pattern_matcher #(.PAT_W(PAT_W), .LEN_W(LEN_W)) u_matcher (
    .clk(clk),
    .rst(rst),
    .clr(clr),
    .en(state_q == RUN && din_valid),
    .no_overlap(!ovl_q),
    .din(din),
    .pattern(pat_q),
    .len(len_q),
    .hit(hit)
  );
  always_comb begin
    state_d = state_q;
    match_d = 1'b0;
    cnt_d = cnt_q;
    irq_d = irq_q;
    pat_d = pat_q;
    len_d = len_q;
    tgt_d = tgt_q;
    ovl_d = ovl_q;
    clr = 1'b0;
    arm = start && !abort && state_q != RUN;
    if (state_q == IDLE && cfg_we) begin
      pat_d = cfg_pattern;
      len_d = LEN_W'(clamp_len(int'(cfg_len), PAT_W));
      tgt_d = cfg_target;
      ovl_d = cfg_overlap;
    end
    if (arm) begin
      state_d = RUN;
      cnt_d = '0;
      irq_d = 1'b0;
      clr = 1'b1;
    end else if (abort && state_q != IDLE) begin
      state_d = IDLE;
    end else if (hit) begin
      match_d = 1'b1;
      cnt_d = &cnt_q ? cnt_q : cnt_q + CNT_W'(1);
      if (tgt_q != '0 && (CNT_W+1)'(cnt_q) + (CNT_W+1)'(1) == (CNT_W+1)'(tgt_q)) begin
        state_d = DONE;
        irq_d = 1'b1;
      end
    end
    busy_d = state_d == RUN;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      match_q <= 1'b0;
      cnt_q <= '0;
      irq_q <= 1'b0;
      busy_q <= 1'b0;
      pat_q <= '0;
      len_q <= LEN_W'(PAT_W);
      tgt_q <= CNT_W'(DEF_TARGET);
      ovl_q <= DEF_OVERLAP;
    end else begin
      state_q <= state_d;
      match_q <= match_d;
      cnt_q <= cnt_d;
      irq_q <= irq_d;
      busy_q <= busy_d;
      pat_q <= pat_d;
      len_q <= len_d;
      tgt_q <= tgt_d;
      ovl_q <= ovl_d;
    end
  end
  assign match = match_q;
  assign match_cnt = cnt_q;
  assign irq = irq_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_pattern_seq_ctrl.sv
// tb_pattern_seq_ctrl: scenario tasks with a match-pulse scoreboard plus inline count/irq/busy checks
module tb_pattern_seq_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic cfg_we = 1'b0, cfg_overlap = 1'b0, start = 1'b0, abort = 1'b0, din = 1'b0, din_valid = 1'b0;
  logic [3:0] cfg_pattern = '0;
  logic [2:0] cfg_len = '0;
  logic [7:0] cfg_target = '0;
  logic match, irq, busy;
  logic [7:0] match_cnt;
  int total = 0, bad = 0;
  logic exp_q[$];
  pattern_seq_ctrl #(.PAT_W(4), .LEN_W(3), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_target(cfg_target), .cfg_overlap(cfg_overlap), .start(start), .abort(abort),
    .din(din), .din_valid(din_valid), .match(match), .match_cnt(match_cnt), .irq(irq), .busy(busy)
  );
  always #5 clk = ~clk;
  always begin
    logic e;
    @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      total++;
      if (match !== e) begin
        bad++;
        $display("FAIL match_pulse got=%b want=%b at %0t", match, e, $time);
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  task automatic step(input logic d, input logic v, input logic s, input logic a, input int e);
    din = d; din_valid = v; start = s; abort = a;
    if (e >= 0) exp_q.push_back(e[0]);
    @(posedge clk);
    #2;
    start = 1'b0; abort = 1'b0; din_valid = 1'b0;
  endtask
  task automatic send(input logic [7:0] bits, input logic [7:0] exps, input int n);
    for (int i = n - 1; i >= 0; i--) step(bits[i], 1'b1, 1'b0, 1'b0, int'(exps[i]));
  endtask
  task automatic cfg(input logic [3:0] p, input logic [2:0] l, input logic [7:0] t, input logic o);
    cfg_pattern = p; cfg_len = l; cfg_target = t; cfg_overlap = o; cfg_we = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, -1);
    cfg_we = 1'b0;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, -1);
    rst = 1'b0;
  endtask
  task automatic test_reset();
    do_reset();
    total++; if ({match, irq, busy} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {match, irq, busy}); end
    total++; if (match_cnt !== 8'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", match_cnt); end
  endtask
  task automatic test_target_done();
    do_reset();
    cfg(4'b1110, 3'd4, 8'd2, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 0);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL t1_busy_run got=%b want=1", busy); end
    send(8'b11101110, 8'b00010001, 8);
    total++; if (match_cnt !== 8'd2) begin bad++; $display("FAIL t1_cnt got=%0d want=2", match_cnt); end
    total++; if ({irq, busy} !== 2'b10) begin bad++; $display("FAIL t1_done got=%b want=10", {irq, busy}); end
    send(8'b00001110, 8'b00000000, 4);
    total++; if (match_cnt !== 8'd2) begin bad++; $display("FAIL t1_done_ignore got=%0d want=2", match_cnt); end
    step(1'b0, 1'b0, 1'b1, 1'b0, 0);
    total++; if ({irq, busy, match_cnt} !== {2'b01, 8'd0}) begin bad++; $display("FAIL t1_restart got=%b want=0100000000", {irq, busy, match_cnt}); end
    send(8'b00001110, 8'b00000001, 4);
    total++; if ({busy, match_cnt} !== {1'b1, 8'd1}) begin bad++; $display("FAIL t1_rerun got=%b want=100000001", {busy, match_cnt}); end
  endtask
  task automatic test_overlap();
    do_reset();
    cfg(4'b0011, 3'd2, 8'd0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 0);
    send(8'b00001111, 8'b00000111, 4);
    total++; if (match_cnt !== 8'd3) begin bad++; $display("FAIL t2_ovl_cnt got=%0d want=3", match_cnt); end
    step(1'b0, 1'b0, 1'b0, 1'b1, 0);
    cfg(4'b0011, 3'd2, 8'd0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 0);
    send(8'b00001111, 8'b00000101, 4);
    total++; if (match_cnt !== 8'd2) begin bad++; $display("FAIL t2_novl_cnt got=%0d want=2", match_cnt); end
    total++; if ({irq, busy} !== 2'b01) begin bad++; $display("FAIL t2_freerun got=%b want=01", {irq, busy}); end
  endtask
  task automatic test_gap_abort();
    do_reset();
    cfg(4'b1110, 3'd4, 8'd5, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 0);
    send(8'b00000111, 8'b00000000, 3);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 0);
    send(8'b00000000, 8'b00000001, 1);
    total++; if (match_cnt !== 8'd1) begin bad++; $display("FAIL t3_cnt got=%0d want=1", match_cnt); end
    step(1'b0, 1'b0, 1'b0, 1'b1, 0);
    total++; if ({irq, busy, match_cnt} !== {2'b00, 8'd1}) begin bad++; $display("FAIL t3_abort got=%b want=0000000001", {irq, busy, match_cnt}); end
  endtask
  task automatic test_cfg_clamp();
    do_reset();
    cfg(4'b0001, 3'd0, 8'd0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 0);
    send(8'b00001011, 8'b00001011, 4);
    total++; if (match_cnt !== 8'd3) begin bad++; $display("FAIL t4_len1_cnt got=%0d want=3", match_cnt); end
    step(1'b0, 1'b0, 1'b0, 1'b1, 0);
    cfg(4'b1110, 3'd7, 8'd0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 0);
    send(8'b00001110, 8'b00000001, 4);
    cfg(4'b0001, 3'd1, 8'd1, 1'b1);
    send(8'b00001110, 8'b00000001, 4);
    total++; if ({busy, match_cnt} !== {1'b1, 8'd2}) begin bad++; $display("FAIL t4_run_cfg got=%b want=100000010", {busy, match_cnt}); end
  endtask
  task automatic test_abort_race();
    do_reset();
    cfg(4'b1110, 3'd4, 8'd0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 0);
    send(8'b00001110, 8'b00000001, 4);
    send(8'b00000111, 8'b00000000, 3);
    step(1'b0, 1'b1, 1'b0, 1'b1, 0);
    total++; if ({busy, match_cnt} !== {1'b0, 8'd1}) begin bad++; $display("FAIL t5_abort_hit got=%b want=000000001", {busy, match_cnt}); end
    step(1'b0, 1'b0, 1'b1, 1'b1, 0);
    total++; if ({busy, match_cnt} !== {1'b0, 8'd1}) begin bad++; $display("FAIL t5_start_abort got=%b want=000000001", {busy, match_cnt}); end
  endtask
  task automatic test_rst_midrun();
    do_reset();
    cfg(4'b1110, 3'd4, 8'd3, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 0);
    send(8'b11101110, 8'b00010001, 8);
    total++; if (match_cnt !== 8'd2) begin bad++; $display("FAIL t6_pre_cnt got=%0d want=2", match_cnt); end
    do_reset();
    total++; if ({match, irq, busy, match_cnt} !== 11'd0) begin bad++; $display("FAIL t6_rst_out got=%b want=0", {match, irq, busy, match_cnt}); end
    step(1'b0, 1'b0, 1'b1, 1'b0, 0);
    send(8'b00001111, 8'b00000000, 4);
    send(8'b00000000, 8'b00000001, 4);
    total++; if ({irq, busy, match_cnt} !== {2'b10, 8'd1}) begin bad++; $display("FAIL t6_defaults got=%b want=1000000001", {irq, busy, match_cnt}); end
  endtask
  initial begin
    test_reset();
    test_target_done();
    test_overlap();
    test_gap_abort();
    test_cfg_clamp();
    test_abort_race();
    test_rst_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
